// File: rtl/nat_pkg.sv
// Shared constants for the NAT connection table: tuple layout, response status codes, FSM states.
package nat_pkg;

    localparam int TUPLE_W      = 104;
    localparam int SRC_IP_LSB   = 72;
    localparam int DST_IP_LSB   = 40;
    localparam int SRC_PORT_LSB = 24;
    localparam int DST_PORT_LSB = 8;
    localparam int PROTO_LSB    = 0;
    localparam int IP_W         = 32;
    localparam int PORT_W       = 16;
    localparam int PROTO_W      = 8;

    localparam logic [1:0] ST_HIT  = 2'b00;
    localparam logic [1:0] ST_NEW  = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;
    localparam logic [1:0] ST_MISS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_OUT_PROBE = 2'd1,
        S_OUT_ALLOC = 2'd2,
        S_IN_LOOK   = 2'd3
    } nat_state_e;

endpackage

// File: rtl/nat_tuple_hash.sv
// Combinational 5-tuple hash: XOR of the low HASH_BITS of every tuple field.
module nat_tuple_hash
    import nat_pkg::*;
#(
    parameter int HASH_BITS = 6
) (
    input  logic [TUPLE_W-1:0]   tuple,
    output logic [HASH_BITS-1:0] index
);

    // Only the low bits of each field feed the hash; the rest is intentionally ignored.
    logic unused_tuple_bits;
    assign unused_tuple_bits = ^tuple;

    always_comb begin
        index = '0;
        for (int i = 0; i < HASH_BITS; i++) begin
            index[i] = tuple[SRC_IP_LSB + i] ^ tuple[DST_IP_LSB + i]
                     ^ tuple[SRC_PORT_LSB + i] ^ tuple[DST_PORT_LSB + i]
                     ^ ((i < PROTO_W) ? tuple[PROTO_LSB + i] : 1'b0);
        end
    end

endmodule

// File: rtl/nat_conn_table.sv
// NAT connection table: outbound linear-probe lookup/allocate, inbound id-indexed reverse lookup.
// Optional saturating statistics counters are built when NAT_STATS_EN is defined.
module nat_conn_table
    import nat_pkg::*;
#(
    parameter int          HASH_BITS = 6,
    parameter int          MAX_PROBE = 2 ** HASH_BITS,
    parameter logic [15:0] PORT_BASE = 16'd1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [TUPLE_W-1:0]   out_tuple,
    input  logic                 out_valid,
    output logic                 out_ready,
    output logic                 out_resp_valid,
    output logic [1:0]           out_resp_status,
    output logic [15:0]          out_resp_port,
    input  logic [TUPLE_W-1:0]   in_tuple,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 in_resp_valid,
    output logic [1:0]           in_resp_status,
    output logic [31:0]          in_resp_ip,
    output logic [15:0]          in_resp_port,
    output logic [HASH_BITS:0]   occupancy,
`ifdef NAT_STATS_EN
    output logic [31:0]          stat_hit,
    output logic [31:0]          stat_new,
    output logic [31:0]          stat_full,
    output logic [31:0]          stat_miss,
`endif
    output logic [1:0]           dbg_state
);

    localparam int D = 1 << HASH_BITS;
    localparam logic [HASH_BITS:0]   D_OCC  = (HASH_BITS + 1)'(D);
    localparam logic [HASH_BITS:0]   MAX_P  = (HASH_BITS + 1)'(MAX_PROBE);
    localparam logic [HASH_BITS:0]   ONE_P  = (HASH_BITS + 1)'(1);
    localparam logic [HASH_BITS-1:0] ONE_ID = HASH_BITS'(1);

    nat_state_e             state_q, state_d;
    logic [TUPLE_W-1:0]     req_q, req_d;
    logic [HASH_BITS-1:0]   slot_q, slot_d, next_id_q, next_id_d;
    logic [HASH_BITS:0]     probes_q, probes_d, occ_q, occ_d;
    logic                   rr_q, rr_d;
    logic [D-1:0]           fwd_valid_q, fwd_valid_d;
    logic                   out_resp_valid_q, out_resp_valid_d, in_resp_valid_q, in_resp_valid_d;
    logic [1:0]             out_resp_status_q, out_resp_status_d, in_resp_status_q, in_resp_status_d;
    logic [15:0]            out_resp_port_q, out_resp_port_d, in_resp_port_q, in_resp_port_d;
    logic [31:0]            in_resp_ip_q, in_resp_ip_d;

    // Table storage: only the valid bits are reset, so a flush clears the table in one cycle.
    logic [TUPLE_W-1:0]     fwd_key_q [D];
    logic [HASH_BITS-1:0]   fwd_id_q  [D];
    logic [TUPLE_W-1:0]     rev_q     [D];
    logic                   alloc_we;

    logic [HASH_BITS-1:0]   out_hash;
    logic                   idle, out_go, in_go, probe_valid, probe_match, in_hit;
    logic [15:0]            in_dport, in_id;
    logic [TUPLE_W-1:0]     rev_e;

    nat_tuple_hash #(.HASH_BITS(HASH_BITS)) u_hash (
        .tuple (out_tuple),
        .index (out_hash)
    );

    // Handshake: a request transfers on the rising edge where valid && ready; ready is high only
    // in IDLE without flush, and when both channels are valid only the round-robin winner sees ready.
    assign idle      = (state_q == S_IDLE);
    assign out_ready = idle && !flush && !(in_valid && rr_q);
    assign in_ready  = idle && !flush && !(out_valid && !rr_q);
    assign out_go    = out_valid && out_ready;
    assign in_go     = in_valid && in_ready;

    assign probe_valid = fwd_valid_q[slot_q];
    assign probe_match = probe_valid && (fwd_key_q[slot_q] == req_q);

    assign in_dport = req_q[DST_PORT_LSB +: PORT_W];
    assign in_id    = in_dport - PORT_BASE;
    assign rev_e    = rev_q[in_id[HASH_BITS-1:0]];
    assign in_hit   = (in_dport >= PORT_BASE) && (in_id < 16'(occ_q))
                   && (rev_e[DST_IP_LSB +: IP_W] == req_q[SRC_IP_LSB +: IP_W])
                   && (rev_e[DST_PORT_LSB +: PORT_W] == req_q[SRC_PORT_LSB +: PORT_W])
                   && (rev_e[PROTO_LSB +: PROTO_W] == req_q[PROTO_LSB +: PROTO_W]);

    always_comb begin
        state_d           = state_q;
        req_d             = req_q;
        slot_d            = slot_q;
        probes_d          = probes_q;
        next_id_d         = next_id_q;
        occ_d             = occ_q;
        rr_d              = rr_q;
        fwd_valid_d       = fwd_valid_q;
        alloc_we          = 1'b0;
        out_resp_valid_d  = 1'b0;
        out_resp_status_d = out_resp_status_q;
        out_resp_port_d   = out_resp_port_q;
        in_resp_valid_d   = 1'b0;
        in_resp_status_d  = in_resp_status_q;
        in_resp_ip_d      = in_resp_ip_q;
        in_resp_port_d    = in_resp_port_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    fwd_valid_d = '0;
                    next_id_d   = '0;
                    occ_d       = '0;
                end else if (out_go) begin
                    req_d    = out_tuple;
                    slot_d   = out_hash;
                    probes_d = '0;
                    rr_d     = 1'b1;
                    state_d  = S_OUT_PROBE;
                end else if (in_go) begin
                    req_d   = in_tuple;
                    rr_d    = 1'b0;
                    state_d = S_IN_LOOK;
                end
            end
            S_OUT_PROBE: begin
                if (probe_match) begin
                    out_resp_valid_d  = 1'b1;
                    out_resp_status_d = ST_HIT;
                    out_resp_port_d   = PORT_BASE + 16'(fwd_id_q[slot_q]);
                    state_d           = S_IDLE;
                end else if (!probe_valid && occ_q < D_OCC) begin
                    state_d = S_OUT_ALLOC;
                end else if (!probe_valid || (probes_q + ONE_P) == MAX_P) begin
                    out_resp_valid_d  = 1'b1;
                    out_resp_status_d = ST_FULL;
                    out_resp_port_d   = 16'd0;
                    state_d           = S_IDLE;
                end else begin
                    slot_d   = slot_q + ONE_ID;
                    probes_d = probes_q + ONE_P;
                end
            end
            S_OUT_ALLOC: begin
                alloc_we            = 1'b1;
                fwd_valid_d[slot_q] = 1'b1;
                out_resp_valid_d    = 1'b1;
                out_resp_status_d   = ST_NEW;
                out_resp_port_d     = PORT_BASE + 16'(next_id_q);
                next_id_d           = next_id_q + ONE_ID;
                occ_d               = occ_q + ONE_P;
                state_d             = S_IDLE;
            end
            S_IN_LOOK: begin
                in_resp_valid_d  = 1'b1;
                in_resp_status_d = in_hit ? ST_HIT : ST_MISS;
                in_resp_ip_d     = in_hit ? rev_e[SRC_IP_LSB +: IP_W] : 32'd0;
                in_resp_port_d   = in_hit ? rev_e[SRC_PORT_LSB +: PORT_W] : 16'd0;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef NAT_STATS_EN
    logic [31:0] stat_hit_q, stat_hit_d, stat_new_q, stat_new_d;
    logic [31:0] stat_full_q, stat_full_d, stat_miss_q, stat_miss_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counters step on the same edge that raises the matching response pulse.
    always_comb begin
        stat_hit_d  = stat_hit_q;
        stat_new_d  = stat_new_q;
        stat_full_d = stat_full_q;
        stat_miss_d = stat_miss_q;
        if (idle && flush) begin
            stat_hit_d  = '0;
            stat_new_d  = '0;
            stat_full_d = '0;
            stat_miss_d = '0;
        end else begin
            if ((out_resp_valid_d && out_resp_status_d == ST_HIT) ||
                (in_resp_valid_d && in_resp_status_d == ST_HIT))
                stat_hit_d = sat_inc(stat_hit_q);
            if (out_resp_valid_d && out_resp_status_d == ST_NEW)  stat_new_d  = sat_inc(stat_new_q);
            if (out_resp_valid_d && out_resp_status_d == ST_FULL) stat_full_d = sat_inc(stat_full_q);
            if (in_resp_valid_d && in_resp_status_d == ST_MISS)   stat_miss_d = sat_inc(stat_miss_q);
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_new  = stat_new_q;
    assign stat_full = stat_full_q;
    assign stat_miss = stat_miss_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            req_q             <= '0;
            slot_q            <= '0;
            probes_q          <= '0;
            next_id_q         <= '0;
            occ_q             <= '0;
            rr_q              <= 1'b0;
            fwd_valid_q       <= '0;
            out_resp_valid_q  <= 1'b0;
            out_resp_status_q <= '0;
            out_resp_port_q   <= '0;
            in_resp_valid_q   <= 1'b0;
            in_resp_status_q  <= '0;
            in_resp_ip_q      <= '0;
            in_resp_port_q    <= '0;
`ifdef NAT_STATS_EN
            stat_hit_q        <= '0;
            stat_new_q        <= '0;
            stat_full_q       <= '0;
            stat_miss_q       <= '0;
`endif
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            slot_q            <= slot_d;
            probes_q          <= probes_d;
            next_id_q         <= next_id_d;
            occ_q             <= occ_d;
            rr_q              <= rr_d;
            fwd_valid_q       <= fwd_valid_d;
            out_resp_valid_q  <= out_resp_valid_d;
            out_resp_status_q <= out_resp_status_d;
            out_resp_port_q   <= out_resp_port_d;
            in_resp_valid_q   <= in_resp_valid_d;
            in_resp_status_q  <= in_resp_status_d;
            in_resp_ip_q      <= in_resp_ip_d;
            in_resp_port_q    <= in_resp_port_d;
`ifdef NAT_STATS_EN
            stat_hit_q        <= stat_hit_d;
            stat_new_q        <= stat_new_d;
            stat_full_q       <= stat_full_d;
            stat_miss_q       <= stat_miss_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_we) begin
            fwd_key_q[slot_q]   <= req_q;
            fwd_id_q[slot_q]    <= next_id_q;
            rev_q[next_id_q]    <= req_q;
        end
    end

    assign out_resp_valid  = out_resp_valid_q;
    assign out_resp_status = out_resp_status_q;
    assign out_resp_port   = out_resp_port_q;
    assign in_resp_valid   = in_resp_valid_q;
    assign in_resp_status  = in_resp_status_q;
    assign in_resp_ip      = in_resp_ip_q;
    assign in_resp_port    = in_resp_port_q;
    assign occupancy       = occ_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_nat_conn_table.sv
// Bench for nat_conn_table: vector table plus hand-written multi-cycle sequences, scoreboard queues.
module tb_nat_conn_table;
    import nat_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush;
    logic [103:0]  out_tuple, in_tuple;
    logic          out_valid, out_ready, in_valid, in_ready;
    logic          out_resp_valid, in_resp_valid;
    logic [1:0]    out_resp_status, in_resp_status, dbg_state;
    logic [15:0]   out_resp_port, in_resp_port;
    logic [31:0]   in_resp_ip;
    logic [6:0]    occupancy;
`ifdef NAT_STATS_EN
    logic [31:0]   stat_hit, stat_new, stat_full, stat_miss;
    logic [31:0]   p_stat_hit, p_stat_new, p_stat_full, p_stat_miss;
`endif

    // Small instance: depth 8, probe bound 4.
    logic          p_flush, p_out_valid, p_out_ready, p_in_valid, p_in_ready;
    logic [103:0]  p_out_tuple, p_in_tuple;
    logic          p_out_resp_valid, p_in_resp_valid;
    logic [1:0]    p_out_resp_status, p_in_resp_status, p_dbg_state;
    logic [15:0]   p_out_resp_port, p_in_resp_port;
    logic [31:0]   p_in_resp_ip;
    logic [3:0]    p_occupancy;

    nat_conn_table dut (
        .clk(clk), .reset(reset), .flush(flush),
        .out_tuple(out_tuple), .out_valid(out_valid), .out_ready(out_ready),
        .out_resp_valid(out_resp_valid), .out_resp_status(out_resp_status), .out_resp_port(out_resp_port),
        .in_tuple(in_tuple), .in_valid(in_valid), .in_ready(in_ready),
        .in_resp_valid(in_resp_valid), .in_resp_status(in_resp_status),
        .in_resp_ip(in_resp_ip), .in_resp_port(in_resp_port),
        .occupancy(occupancy),
`ifdef NAT_STATS_EN
        .stat_hit(stat_hit), .stat_new(stat_new), .stat_full(stat_full), .stat_miss(stat_miss),
`endif
        .dbg_state(dbg_state)
    );

    nat_conn_table #(.HASH_BITS(3), .MAX_PROBE(4)) dut_p (
        .clk(clk), .reset(reset), .flush(p_flush),
        .out_tuple(p_out_tuple), .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_resp_valid(p_out_resp_valid), .out_resp_status(p_out_resp_status), .out_resp_port(p_out_resp_port),
        .in_tuple(p_in_tuple), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_resp_valid(p_in_resp_valid), .in_resp_status(p_in_resp_status),
        .in_resp_ip(p_in_resp_ip), .in_resp_port(p_in_resp_port),
        .occupancy(p_occupancy),
`ifdef NAT_STATS_EN
        .stat_hit(p_stat_hit), .stat_new(p_stat_new), .stat_full(p_stat_full), .stat_miss(p_stat_miss),
`endif
        .dbg_state(p_dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int last_grant = 0;  // 0 = outbound, 1 = inbound
    logic [17:0] out_exp_q[$];
    logic [49:0] in_exp_q[$];
    logic [17:0] p_exp_q[$];
    logic [17:0] out_e, p_e;
    logic [49:0] in_e;

    typedef struct {
        logic          is_in;
        logic [103:0]  tuple;
        logic [1:0]    st;
        logic [31:0]   ip;
        logic [15:0]   port;
        int            lat;
        int            occ;
    } vec_t;
    vec_t vecs[12];

    function automatic logic [103:0] mk(input logic [31:0] sip, input logic [31:0] dip,
                                        input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] pr);
        return {sip, dip, sp, dp, pr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no event within the cycle budget, required one", name);
    endtask

    // Latency is counted in clock edges with the accept edge counted as 1.
    task automatic do_out(input logic [103:0] t, input logic [1:0] st, input logic [15:0] port, input int lat_exp);
        int n;
        int lat;
        out_tuple = t;
        out_valid = 1'b1;
        #1;
        n = 0;
        while (!out_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!out_ready) begin timeout("out_accept"); out_valid = 1'b0; return; end
        out_exp_q.push_back({st, port});
        @(posedge clk); #1;
        out_valid = 1'b0;
        last_grant = 0;
        lat = 1;
        @(negedge clk);
        while (!out_resp_valid && lat < 200) begin @(negedge clk); lat++; end
        if (!out_resp_valid) timeout("out_resp");
        else if (lat_exp > 0) chk("out_latency", 64'(lat), 64'(lat_exp));
    endtask

    task automatic do_in(input logic [103:0] t, input logic [1:0] st, input logic [31:0] ip,
                         input logic [15:0] port, input int lat_exp);
        int n;
        int lat;
        in_tuple = t;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!in_ready) begin timeout("in_accept"); in_valid = 1'b0; return; end
        in_exp_q.push_back({st, ip, port});
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_grant = 1;
        lat = 1;
        @(negedge clk);
        while (!in_resp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!in_resp_valid) timeout("in_resp");
        else if (lat_exp > 0) chk("in_latency", 64'(lat), 64'(lat_exp));
    endtask

    task automatic p_do_out(input logic [103:0] t, input logic [1:0] st, input logic [15:0] port, input int lat_exp);
        int n;
        int lat;
        p_out_tuple = t;
        p_out_valid = 1'b1;
        #1;
        n = 0;
        while (!p_out_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!p_out_ready) begin timeout("p_out_accept"); p_out_valid = 1'b0; return; end
        p_exp_q.push_back({st, port});
        @(posedge clk); #1;
        p_out_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!p_out_resp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!p_out_resp_valid) timeout("p_out_resp");
        else chk("p_out_latency", 64'(lat), 64'(lat_exp));
    endtask

    // Scoreboard monitors: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (out_resp_valid) begin
            if (out_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexpected: got status %0d port %0d, required no response", out_resp_status, out_resp_port);
            end else begin
                out_e = out_exp_q.pop_front();
                chk("out_resp", 64'({out_resp_status, out_resp_port}), 64'(out_e));
            end
        end
        if (in_resp_valid) begin
            if (in_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL in_unexpected: got status %0d, required no response", in_resp_status);
            end else begin
                in_e = in_exp_q.pop_front();
                chk("in_resp", 64'({in_resp_status, in_resp_ip, in_resp_port}), 64'(in_e));
            end
        end
        if (p_out_resp_valid) begin
            if (p_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL p_out_unexpected: got status %0d, required no response", p_out_resp_status);
            end else begin
                p_e = p_exp_q.pop_front();
                chk("p_out_resp", 64'({p_out_resp_status, p_out_resp_port}), 64'(p_e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] t1, t1b, t_a, t_b, in1, t_full, in_last;
        logic [103:0] fill_t[64];
        logic [31:0] nat_ip;
        int exp_kind, got_kind, n;

        nat_ip = 32'hC0A8_0001;
        t1     = mk(32'h0A00_0002, 32'h0808_0808, 16'd5000, 16'd53, 8'd17);   // hash 38
        t1b    = mk(32'h0A00_0003, 32'h0808_0809, 16'd5000, 16'd53, 8'd17);   // hash 38
        t_a    = mk(32'h0A00_001B, 32'h0808_0808, 16'd5000, 16'd53, 8'd17);   // hash 63
        t_b    = mk(32'h0A00_001A, 32'h0808_0809, 16'd5000, 16'd53, 8'd17);   // hash 63, wraps to 0
        in1    = mk(32'h0808_0808, nat_ip, 16'd53, 16'd1024, 8'd17);

        vecs[0]  = '{1'b0, t1,  ST_NEW,  32'd0, 16'd1024, 3, 1};
        vecs[1]  = '{1'b0, t1,  ST_HIT,  32'd0, 16'd1024, 2, 1};
        vecs[2]  = '{1'b1, in1, ST_HIT,  32'h0A00_0002, 16'd5000, 2, 1};
        vecs[3]  = '{1'b1, mk(32'h0808_0808, nat_ip, 16'd54, 16'd1024, 8'd17), ST_MISS, 32'd0, 16'd0, 2, 1};
        vecs[4]  = '{1'b1, mk(32'h0808_0808, nat_ip, 16'd53, 16'd1000, 8'd17), ST_MISS, 32'd0, 16'd0, 2, 1};
        vecs[5]  = '{1'b0, t1b, ST_NEW,  32'd0, 16'd1025, 4, 2};
        vecs[6]  = '{1'b0, t1b, ST_HIT,  32'd0, 16'd1025, 3, 2};
        vecs[7]  = '{1'b0, t_a, ST_NEW,  32'd0, 16'd1026, 3, 3};
        vecs[8]  = '{1'b0, t_b, ST_NEW,  32'd0, 16'd1027, 4, 4};
        vecs[9]  = '{1'b0, t_b, ST_HIT,  32'd0, 16'd1027, 3, 4};
        vecs[10] = '{1'b1, mk(32'h0808_0809, nat_ip, 16'd53, 16'd1027, 8'd17), ST_HIT, 32'h0A00_001A, 16'd5000, 2, 4};
        vecs[11] = '{1'b1, mk(32'h0808_0808, nat_ip, 16'd53, 16'd1028, 8'd17), ST_MISS, 32'd0, 16'd0, 2, 4};

        reset = 1'b0; flush = 1'b0;
        out_tuple = '0; out_valid = 1'b0; in_tuple = '0; in_valid = 1'b0;
        p_flush = 1'b0; p_out_tuple = '0; p_out_valid = 1'b0; p_in_tuple = '0; p_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_resp_valid", 64'(out_resp_valid), 64'd0);
        chk("rst_in_resp_valid", 64'(in_resp_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        chk("rst_out_port", 64'(out_resp_port), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_in) do_in(vecs[i].tuple, vecs[i].st, vecs[i].ip, vecs[i].port, vecs[i].lat);
            else do_out(vecs[i].tuple, vecs[i].st, vecs[i].port, vecs[i].lat);
            chk($sformatf("occ_vec%0d", i), 64'(occupancy), 64'(vecs[i].occ));
        end

        // Bounded probing on the small instance: 5 tuples sharing one hash.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) p_do_out(mk(32'h0A00_0002, 32'h0808_0808, 16'h1000 + 16'(i * 8), 16'd53, 8'd17),
                                ST_NEW, 16'd1024 + 16'(i), i + 3);
            else p_do_out(mk(32'h0A00_0002, 32'h0808_0808, 16'h1000 + 16'(i * 8), 16'd53, 8'd17),
                          ST_FULL, 16'd0, 5);
        end
        chk("p_occupancy", 64'(p_occupancy), 64'd4);

        // Fill the remaining ids with distinct tuples, then overflow.
        for (int i = 4; i < 64; i++) begin
            fill_t[i] = mk({16'h0A01, 16'($urandom_range(0, 65535))}, 32'h0101_0101, 16'h2000 + 16'(i), 16'd80, 8'd6);
            do_out(fill_t[i], ST_NEW, 16'd1024 + 16'(i), 0);
        end
        chk("occ_full", 64'(occupancy), 64'd64);
        t_full = mk(32'h0A02_0001, 32'h0101_0101, 16'h3000, 16'd80, 8'd6);
        do_out(t_full, ST_FULL, 16'd0, 65);
        chk("occ_after_full", 64'(occupancy), 64'd64);
        do_out(t1, ST_HIT, 16'd1024, 2);
        in_last = mk(32'h0101_0101, nat_ip, 16'd80, 16'd1087, 8'd6);
        do_in(in_last, ST_HIT, fill_t[63][103:72], 16'h203F, 2);

        // Both channels held valid: grants must alternate.
        exp_kind = (last_grant == 0) ? 1 : 0;
        out_tuple = t1; in_tuple = in1; out_valid = 1'b1; in_valid = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(out_ready || in_ready) && n < 50) begin @(negedge clk); #1; n++; end
            if (!(out_ready || in_ready)) begin timeout("rr_grant"); break; end
            got_kind = in_ready ? 1 : 0;
            chk($sformatf("rr_grant%0d", g), 64'(got_kind), 64'(exp_kind));
            if (got_kind == 0) out_exp_q.push_back({ST_HIT, 16'd1024});
            else in_exp_q.push_back({ST_HIT, 32'h0A00_0002, 16'd5000});
            last_grant = got_kind;
            exp_kind = 1 - got_kind;
            if (g < 3) begin @(negedge clk); #1; end
        end
        @(posedge clk); #1;
        out_valid = 1'b0; in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Flush in IDLE blocks requests for that cycle and empties the table.
        out_tuple = t1; out_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_out_ready", 64'(out_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; out_valid = 1'b0;
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        do_in(in1, ST_MISS, 32'd0, 16'd0, 2);
        do_out(t1, ST_NEW, 16'd1024, 3);
        chk("occ_after_flush_new", 64'(occupancy), 64'd1);

        // Reset while probing: the in-flight request vanishes without a response.
        out_tuple = t1b; out_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        out_valid = 1'b0;
        chk("probe_state", 64'(dbg_state), 64'(S_OUT_PROBE));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst2_state", 64'(dbg_state), 64'(S_IDLE));
        chk("rst2_out_resp_valid", 64'(out_resp_valid), 64'd0);
        chk("rst2_occupancy", 64'(occupancy), 64'd0);
        chk("rst2_out_port", 64'(out_resp_port), 64'd0);
        chk("rst2_in_status", 64'(in_resp_status), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        do_out(t1, ST_NEW, 16'd1024, 3);
        do_in(in1, ST_HIT, 32'h0A00_0002, 16'd5000, 2);

        repeat (5) @(negedge clk);
        chk("out_queue_empty", 64'(out_exp_q.size()), 64'd0);
        chk("in_queue_empty", 64'(in_exp_q.size()), 64'd0);
        chk("p_queue_empty", 64'(p_exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
